sram_arb_2port: RTL

SRAM_ARB_2PORT -- requirements
Module: sram_arb_2port

---
 rtl/sram_arb_pkg.sv | 14 +
 rtl/sram_arb_2port_rr_arb2.sv | 36 +++
 rtl/sram_arb_2port.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-client SRAM arbiter.
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/sram_arb_2port_rr_arb2.sv
// Two-way winner select. Round-robin with a 1-bit pointer by default;
// fixed priority to client 0 when SRAM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       arb_en,
    output logic       grant,
    output logic       winner,
    output logic       ptr
);

    assign grant = arb_en && (req != 2'b00);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign winner = ~req[0];

    // No rotation in this mode; ptr is kept only as a constant debug view.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= 1'b0;
        else     ptr <= 1'b0;
    end
`else
    // On a conflict the pointer's client wins; a lone requester always wins.
    always_comb begin
        if (req[0] && req[1]) winner = ptr;
        else                  winner = req[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        ptr <= 1'b0;
        else if (grant) ptr <= ~winner;
    end
`endif

endmodule

// File: rtl/sram_arb_2port.sv
// Two-client arbiter in front of a single-port registered-read SRAM.
// Optional build macro: SRAM_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module sram_arb_2port
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              we,
    output logic              en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] data_w,
    input  logic [DATA_W-1:0] data_r,
    output state_t            dbg_state,
    output logic              dbg_ptr
);

    // Handshake: a client holds reqN (with rw/addr/wdata) until it sees gntN;
    // gntN is the acceptance pulse, and a read returns one rvalidN pulse later.
    state_t            state, state_nx;
    logic              lat_id;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_hold;
    logic              arb_grant;
    logic              arb_winner;
    logic              sel_rw;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1, req0}),
        .arb_en (state == ST_IDLE),
        .grant  (arb_grant),
        .winner (arb_winner),
        .ptr    (dbg_ptr)
    );

    assign sel_rw = arb_winner ? rw1 : rw0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (arb_grant) state_nx = sel_rw ? ST_WRITE : ST_READ;
            ST_WRITE: state_nx = ST_IDLE;
            ST_READ:  state_nx = ST_RESP;
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Only the winner's fields are captured; the loser's stay on its own bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_id     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_hold <= '0;
        end else begin
            if (arb_grant) begin
                lat_id    <= arb_winner;
                lat_addr  <= arb_winner ? addr1 : addr0;
                lat_wdata <= arb_winner ? wdata1 : wdata0;
            end
            if (state == ST_RESP) rdata_hold <= data_r;
        end
    end

    always_comb begin
        we      = 1'b0;
        en      = 1'b0;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        rvalid0 = 1'b0;
        rvalid1 = 1'b0;
        rdata   = rdata_hold;
        case (state)
            ST_WRITE: begin
                we   = 1'b1;
                gnt0 = ~lat_id;
                gnt1 = lat_id;
            end
            ST_READ: begin
                en   = 1'b1;
                gnt0 = ~lat_id;
                gnt1 = lat_id;
            end
            ST_RESP: begin
                rvalid0 = ~lat_id;
                rvalid1 = lat_id;
                rdata   = data_r;
            end
            default: ;
        endcase
    end

    assign w_addr    = lat_addr;
    assign r_addr    = lat_addr;
    assign data_w    = lat_wdata;
    assign dbg_state = state;

endmodule
